// File: rtl/mc_pkg.sv
// Shared definitions for the multicast array controller: FSM encoding and broadcast-tag rule.
package mc_pkg;

    typedef enum logic {
        EMPTY   = 1'b0,
        DELIVER = 1'b1
    } mc_state_e;

    // A tag is a broadcast tag when its low 'width' bits (1..32) are all ones.
    function automatic logic is_broadcast(input logic [31:0] tag, input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (tag & mask) == mask;
    endfunction

endpackage

// File: rtl/mc_tag_slot.sv
// One destination unit's tag register plus its match comparator.
module mc_tag_slot
    import mc_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     prog_we,
    input  logic [ADDRESS_WIDTH-1:0] prog_tag,
    input  logic [ADDRESS_WIDTH-1:0] in_tag,
    output logic                     match
);

    logic [ADDRESS_WIDTH-1:0] tag_q;

    // Tag register; a write in the same cycle as an acceptance is seen only by later transfers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            tag_q <= '0;
        end else if (prog_we) begin
            tag_q <= prog_tag;
        end
    end

    // Match on the stored tag, or on the all-ones broadcast tag.
    always_comb begin
        match = (in_tag == tag_q) || is_broadcast(32'(in_tag), ADDRESS_WIDTH);
    end

endmodule

// File: rtl/multicast_array_controller.sv
// Single-entry multicast buffer: accepts one tagged transfer and delivers it to every matching unit.
module multicast_array_controller
    import mc_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned BITWIDTH      = 16,
    parameter int unsigned NUM_UNITS     = 8,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         prog_en,
    input  logic [$clog2(NUM_UNITS)-1:0] prog_unit,
    input  logic [ADDRESS_WIDTH-1:0]     prog_tag,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDRESS_WIDTH-1:0]     in_tag,
    input  logic [BITWIDTH-1:0]          in_data,
    output logic [NUM_UNITS-1:0]         unit_valid,
    input  logic [NUM_UNITS-1:0]         unit_ready,
    output logic [BITWIDTH-1:0]          out_data,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam int unsigned UnitW = $clog2(NUM_UNITS);

    mc_state_e            state_q, state_d;
    logic [NUM_UNITS-1:0] pending_q, pending_d;
    logic [BITWIDTH-1:0]  data_q, data_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [NUM_UNITS-1:0] match_mask;
    logic                 accept;

    // Out-of-range prog_unit never equals any slot index, so it is ignored.
    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
        mc_tag_slot #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_slot (
            .clk      (clk),
            .rstb     (rstb),
            .prog_we  (prog_en && (prog_unit == UnitW'(i))),
            .prog_tag (prog_tag),
            .in_tag   (in_tag),
            .match    (match_mask[i])
        );
    end

    // State, pending mask, held data and drop counter.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= EMPTY;
            pending_q <= '0;
            data_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
        end
    end

    // Ready when idle, or when every remaining pending unit takes the data this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (rstb) begin
            if (state_q == EMPTY) begin
                in_ready = 1'b1;
            end else begin
                in_ready = (pending_q & ~unit_ready) == '0;
            end
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state: retire acknowledged units, then load a new transfer or count a drop.
    always_comb begin
        pending_d = pending_q & ~unit_ready;
        data_d    = data_q;
        drop_d    = drop_q;
        if (accept) begin
            if (match_mask != '0) begin
                pending_d = match_mask;
                data_d    = in_data;
            end else if (drop_q != '1) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
        state_d = (pending_d != '0) ? DELIVER : EMPTY;
    end

    assign unit_valid = pending_q;
    assign out_data   = data_q;
    assign busy       = (state_q == DELIVER);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_multicast_array_controller.sv
// Directed bench for multicast_array_controller with hand-computed expectations.
module tb_multicast_array_controller;

    logic        clk;
    logic        rstb;
    logic        prog_en;
    logic [2:0]  prog_unit;
    logic [3:0]  prog_tag;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [15:0] in_data;
    logic [7:0]  unit_valid;
    logic [7:0]  unit_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    multicast_array_controller #(
        .ADDRESS_WIDTH (4),
        .BITWIDTH      (16),
        .NUM_UNITS     (8),
        .CNT_WIDTH     (8)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .prog_en    (prog_en),
        .prog_unit  (prog_unit),
        .prog_tag   (prog_tag),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .in_data    (in_data),
        .unit_valid (unit_valid),
        .unit_ready (unit_ready),
        .out_data   (out_data),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus-only helper: write one tag register.
    task automatic prog(input logic [2:0] unit, input logic [3:0] tag);
        @(negedge clk);
        prog_en   = 1'b1;
        prog_unit = unit;
        prog_tag  = tag;
        @(negedge clk);
        prog_en = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (unit_valid !== 8'h00) begin
            bad++; $display("FAIL reset_unit_valid got=%h want=00", unit_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (drop_count !== 8'h00) begin
            bad++; $display("FAIL reset_drop got=%h want=00", drop_count);
        end
        total++;
        if (out_data !== 16'h0000) begin
            bad++; $display("FAIL reset_out_data got=%h want=0000", out_data);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        prog(3'd3, 4'h5);
        unit_ready = 8'hFF;
        in_valid = 1'b1; in_tag = 4'h5; in_data = 16'hBEEF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready_empty got=%b want=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (unit_valid !== 8'h08) begin
            bad++; $display("FAIL single_unit_valid got=%h want=08", unit_valid);
        end
        total++;
        if (out_data !== 16'hBEEF) begin
            bad++; $display("FAIL single_out_data got=%h want=beef", out_data);
        end
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_ready_busy got=%b%b want=11", in_ready, busy);
        end
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL single_done got=%h/%b want=00/0", unit_valid, busy);
        end
    endtask

    task automatic test_partial();
        prog(3'd1, 4'hA);
        prog(3'd2, 4'hA);
        unit_ready = 8'hFB;
        in_valid = 1'b1; in_tag = 4'hA; in_data = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (unit_valid !== 8'h06 || in_ready !== 1'b0) begin
            bad++; $display("FAIL partial_first got=%h/%b want=06/0", unit_valid, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (unit_valid !== 8'h04 || in_ready !== 1'b0) begin
                bad++; $display("FAIL partial_hold%0d got=%h/%b want=04/0", c, unit_valid, in_ready);
            end
        end
        unit_ready = 8'hFF;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL partial_release_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL partial_empty got=%h/%b want=00/0", unit_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        unit_ready = 8'hFF;
        in_valid = 1'b1; in_tag = 4'hF; in_data = 16'h1111;
        @(negedge clk);
        in_tag = 4'h5; in_data = 16'h2222;
        #1;
        total++;
        if (unit_valid !== 8'hFF || out_data !== 16'h1111) begin
            bad++; $display("FAIL b2b_bcast got=%h/%h want=ff/1111", unit_valid, out_data);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (unit_valid !== 8'h08 || out_data !== 16'h2222) begin
            bad++; $display("FAIL b2b_second got=%h/%h want=08/2222", unit_valid, out_data);
        end
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00) begin
            bad++; $display("FAIL b2b_done got=%h want=00", unit_valid);
        end
    endtask

    task automatic test_drop_saturate();
        int spurious = 0;
        unit_ready = 8'hFF;
        in_valid = 1'b1; in_tag = 4'h7; in_data = 16'h7777;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (unit_valid !== 8'h00) spurious++;
            if (c == 2) begin
                total++;
                if (drop_count !== 8'd3) begin
                    bad++; $display("FAIL drop_early got=%0d want=3", drop_count);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (spurious != 0) begin
            bad++; $display("FAIL drop_no_valid got=%0d want=0 cycles", spurious);
        end
        total++;
        if (drop_count !== 8'hFF) begin
            bad++; $display("FAIL drop_saturate got=%h want=ff", drop_count);
        end
    endtask

    task automatic test_reset_mid();
        prog(3'd4, 4'h6);
        prog(3'd5, 4'h6);
        unit_ready = 8'h00;
        in_valid = 1'b1; in_tag = 4'h6; in_data = 16'h6666;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (unit_valid !== 8'h30) begin
            bad++; $display("FAIL rstmid_pending got=%h want=30", unit_valid);
        end
        rstb = 1'b0;
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00 || busy !== 1'b0 || drop_count !== 8'h00 || in_ready !== 1'b0)
        begin
            bad++;
            $display("FAIL rstmid_state got uv=%h busy=%b drop=%h rdy=%b want 00/0/00/0",
                     unit_valid, busy, drop_count, in_ready);
        end
        rstb = 1'b1;
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00) begin
            bad++; $display("FAIL rstmid_no_resume got=%h want=00", unit_valid);
        end
        // All tags reset to 0, so tag 0 must hit every unit.
        unit_ready = 8'hFF;
        in_valid = 1'b1; in_tag = 4'h0; in_data = 16'h0A0A;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (unit_valid !== 8'hFF) begin
            bad++; $display("FAIL rstmid_tags_zero got=%h want=ff", unit_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reprogram();
        prog(3'd0, 4'h2);
        unit_ready = 8'h00;
        in_valid = 1'b1; in_tag = 4'h2; in_data = 16'h3333;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (unit_valid !== 8'h01) begin
            bad++; $display("FAIL reprog_start got=%h want=01", unit_valid);
        end
        prog_en = 1'b1; prog_unit = 3'd0; prog_tag = 4'h3;
        @(negedge clk);
        prog_en = 1'b0;
        total++;
        if (unit_valid !== 8'h01 || out_data !== 16'h3333) begin
            bad++; $display("FAIL reprog_hold got=%h/%h want=01/3333", unit_valid, out_data);
        end
        unit_ready = 8'hFF;
        @(negedge clk);
        total++;
        if (unit_valid !== 8'h00) begin
            bad++; $display("FAIL reprog_complete got=%h want=00", unit_valid);
        end
        in_valid = 1'b1; in_tag = 4'h2; in_data = 16'h4444;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (unit_valid !== 8'h00 || drop_count !== 8'd1) begin
            bad++; $display("FAIL reprog_old_tag_drop got=%h/%0d want=00/1", unit_valid, drop_count);
        end
        // Program and accept together: the match must use the old tag (3).
        prog_en = 1'b1; prog_unit = 3'd0; prog_tag = 4'h9;
        in_valid = 1'b1; in_tag = 4'h3; in_data = 16'h5555;
        @(negedge clk);
        prog_en = 1'b0; in_valid = 1'b0;
        total++;
        if (unit_valid !== 8'h01 || out_data !== 16'h5555) begin
            bad++; $display("FAIL prog_accept_same got=%h/%h want=01/5555", unit_valid, out_data);
        end
        @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; prog_en = 1'b0; prog_unit = '0; prog_tag = '0;
        in_valid = 1'b0; in_tag = '0; in_data = '0; unit_ready = '0;
        test_reset();
        test_single();
        test_partial();
        test_back_to_back();
        test_drop_saturate();
        test_reset_mid();
        test_reprogram();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
